panxi_ctrl: RTL and testbench

PANXI_CTRL -- requirements
Module: panxi_ctrl

---
 rtl/panxi_ctrl_pkg.sv | 19 +
 rtl/panxi_ctrl.sv | 172 +++++++++++++++++
 tb/tb_panxi_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/panxi_ctrl_pkg.sv
// Shared constants for the pipeline control block: hold codes, datapath width
// and FSM state encodings.
package panxi_ctrl_pkg;

  localparam int unsigned PANXI_DW   = 32;
  localparam int unsigned HOLD_WIDTH = 3;

  localparam logic [HOLD_WIDTH-1:0] HOLD_NONE = 3'd0;
  localparam logic [HOLD_WIDTH-1:0] HOLD_PC   = 3'd1;
  localparam logic [HOLD_WIDTH-1:0] HOLD_IF   = 3'd2;
  localparam logic [HOLD_WIDTH-1:0] HOLD_ID   = 3'd3;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StPend = 2'd1,
    StHalt = 2'd2
  } panxi_state_e;

endpackage

// File: rtl/panxi_ctrl.sv
// Pipeline control: arbitrates redirect requests (interrupt over execute jump),
// defers a redirect while the bus arbiter or debug halt stalls the core, and
// produces the pipeline hold code.
// Optional feature: define PANXI_CTRL_TIMEOUT_EN to build the sticky bus-hold
// timeout detector; otherwise hold_timeout_xo is tied low.
module panxi_ctrl
  import panxi_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jmp_req_ex_xi,
  input  logic [PANXI_DW-1:0]   jmp_addr_ex_xi,
  input  logic                  hold_req_ex_xi,
  input  logic                  int_req_xi,
  input  logic [PANXI_DW-1:0]   int_addr_xi,
  input  logic                  hold_req_rib_xi,
  input  logic                  halt_req_jtag_xi,
  output logic                  jmp_en_xo,
  output logic [PANXI_DW-1:0]   jmp_addr_xo,
  output logic [HOLD_WIDTH-1:0] hold_flag_xo,
  output logic                  pend_xo,
  output logic                  halted_xo,
  output logic                  hold_timeout_xo
);

  panxi_state_e        state_q, state_d;
  logic                slot_vld_q, slot_vld_d;
  logic [PANXI_DW-1:0] slot_addr_q, slot_addr_d;
  logic                timeout_flag;

  // Interrupt wins; a simultaneous execute jump is dropped.
  logic                req_vld;
  logic [PANXI_DW-1:0] req_addr;
  assign req_vld  = int_req_xi | jmp_req_ex_xi;
  assign req_addr = int_req_xi ? int_addr_xi : jmp_addr_ex_xi;

  // State and pending-slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      slot_vld_q  <= 1'b0;
      slot_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      slot_vld_q  <= slot_vld_d;
      slot_addr_q <= slot_addr_d;
    end
  end

  // Next state, slot update, redirect issue and hold code.
  always_comb begin
    logic                issue;
    logic [PANXI_DW-1:0] issue_addr;
    state_d     = state_q;
    slot_vld_d  = slot_vld_q;
    slot_addr_d = slot_addr_q;
    issue       = 1'b0;
    issue_addr  = '0;

    unique case (state_q)
      StRun: begin
        if (halt_req_jtag_xi) begin
          // Keep a redirect arriving with the halt so it is not lost.
          state_d = StHalt;
          if (req_vld) begin
            slot_vld_d  = 1'b1;
            slot_addr_d = req_addr;
          end
        end else if (hold_req_rib_xi) begin
          if (req_vld) begin
            slot_vld_d  = 1'b1;
            slot_addr_d = req_addr;
            state_d     = StPend;
          end
        end else if (req_vld) begin
          issue      = 1'b1;
          issue_addr = req_addr;
        end
      end
      StPend: begin
        // Only an interrupt may replace the captured target.
        if (int_req_xi) begin
          slot_addr_d = int_addr_xi;
        end
        if (halt_req_jtag_xi) begin
          state_d = StHalt;
        end else if (!hold_req_rib_xi) begin
          issue      = 1'b1;
          issue_addr = slot_addr_d;
          slot_vld_d = 1'b0;
          state_d    = StRun;
        end
      end
      StHalt: begin
        if (int_req_xi) begin
          slot_vld_d  = 1'b1;
          slot_addr_d = int_addr_xi;
        end
        if (!halt_req_jtag_xi) begin
          state_d = slot_vld_d ? StPend : StRun;
        end
      end
      default: begin
        state_d    = StRun;
        slot_vld_d = 1'b0;
      end
    endcase

    jmp_en_xo       = issue;
    jmp_addr_xo     = issue ? issue_addr : '0;
    pend_xo         = slot_vld_q;
    halted_xo       = (state_q == StHalt);
    hold_timeout_xo = timeout_flag;

    if (halt_req_jtag_xi || (state_q == StHalt)) begin
      hold_flag_xo = HOLD_ID;
    end else if (hold_req_rib_xi) begin
      hold_flag_xo = HOLD_PC;
    end else if (issue) begin
      hold_flag_xo = HOLD_ID;
    end else if (hold_req_ex_xi) begin
      hold_flag_xo = HOLD_ID;
    end else begin
      hold_flag_xo = HOLD_NONE;
    end

    // Outputs are forced quiet while reset is applied, whatever the inputs.
    if (rst) begin
      jmp_en_xo       = 1'b0;
      jmp_addr_xo     = '0;
      hold_flag_xo    = HOLD_NONE;
      pend_xo         = 1'b0;
      halted_xo       = 1'b0;
      hold_timeout_xo = 1'b0;
    end
  end

`ifdef PANXI_CTRL_TIMEOUT_EN
  localparam logic [7:0] TimeoutThr = 8'(TIMEOUT_CYC);

  logic [7:0] to_cnt_q, to_cnt_d;
  logic       to_flag_q;

  // Saturating count of consecutive bus-hold cycles.
  always_comb begin
    to_cnt_d = 8'd0;
    if (hold_req_rib_xi) begin
      to_cnt_d = (to_cnt_q == 8'hFF) ? to_cnt_q : to_cnt_q + 8'd1;
    end
  end

  // Counter register and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= 8'd0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      if (to_cnt_d >= TimeoutThr) begin
        to_flag_q <= 1'b1;
      end
    end
  end

  assign timeout_flag = to_flag_q;
`else
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_panxi_ctrl.sv
// Directed bench for panxi_ctrl: reset, direct redirect, deferred redirect,
// source priority, halt during pending, reset discard and bus-hold timeout.
module tb_panxi_ctrl;
  import panxi_ctrl_pkg::*;

`ifdef PANXI_CTRL_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic                  clk;
  logic                  rst;
  logic                  jmp_req_ex_xi;
  logic [PANXI_DW-1:0]   jmp_addr_ex_xi;
  logic                  hold_req_ex_xi;
  logic                  int_req_xi;
  logic [PANXI_DW-1:0]   int_addr_xi;
  logic                  hold_req_rib_xi;
  logic                  halt_req_jtag_xi;
  logic                  jmp_en_xo;
  logic [PANXI_DW-1:0]   jmp_addr_xo;
  logic [HOLD_WIDTH-1:0] hold_flag_xo;
  logic                  pend_xo;
  logic                  halted_xo;
  logic                  hold_timeout_xo;

  int checks = 0;
  int errors = 0;

  panxi_ctrl #(
    .TIMEOUT_CYC(4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .jmp_req_ex_xi   (jmp_req_ex_xi),
    .jmp_addr_ex_xi  (jmp_addr_ex_xi),
    .hold_req_ex_xi  (hold_req_ex_xi),
    .int_req_xi      (int_req_xi),
    .int_addr_xi     (int_addr_xi),
    .hold_req_rib_xi (hold_req_rib_xi),
    .halt_req_jtag_xi(halt_req_jtag_xi),
    .jmp_en_xo       (jmp_en_xo),
    .jmp_addr_xo     (jmp_addr_xo),
    .hold_flag_xo    (hold_flag_xo),
    .pend_xo         (pend_xo),
    .halted_xo       (halted_xo),
    .hold_timeout_xo (hold_timeout_xo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then applied 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    jmp_req_ex_xi    = 1'b0;
    jmp_addr_ex_xi   = '0;
    hold_req_ex_xi   = 1'b0;
    int_req_xi       = 1'b0;
    int_addr_xi      = '0;
    hold_req_rib_xi  = 1'b0;
    halt_req_jtag_xi = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic en, input logic [31:0] addr,
                         input logic [2:0] hold, input logic pend, input logic halted);
    check({tag, ".jmp_en"}, 32'(jmp_en_xo), 32'(en));
    if (en) check({tag, ".jmp_addr"}, jmp_addr_xo, addr);
    check({tag, ".hold"}, 32'(hold_flag_xo), 32'(hold));
    check({tag, ".pend"}, 32'(pend_xo), 32'(pend));
    check({tag, ".halted"}, 32'(halted_xo), 32'(halted));
  endtask

  initial begin
    // Reset with busy inputs: all outputs must be quiet.
    idle();
    rst = 1'b1;
    jmp_req_ex_xi = 1'b1; jmp_addr_ex_xi = 32'h100;
    hold_req_ex_xi = 1'b1; halt_req_jtag_xi = 1'b1;
    #1;
    chk_out("rst0", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    check("rst0.jmp_addr", jmp_addr_xo, 32'h0);
    check("rst0.timeout", 32'(hold_timeout_xo), 32'h0);
    cyc();
    chk_out("rst1", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    cyc();
    rst = 1'b0;
    idle();

    // Idle after reset.
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_out("idle", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
      check("idle.timeout", 32'(hold_timeout_xo), 32'h0);
      cyc();
    end

    // Direct execute jump: same-cycle redirect.
    jmp_req_ex_xi = 1'b1; jmp_addr_ex_xi = 32'h100;
    #1;
    chk_out("exjmp", 1'b1, 32'h100, 3'd3, 1'b0, 1'b0);
    cyc();
    idle();
    #1;
    chk_out("exjmp_after", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    cyc();

    // Execute multi-cycle stall alone.
    hold_req_ex_xi = 1'b1;
    #1;
    chk_out("exhold", 1'b0, 32'h0, 3'd3, 1'b0, 1'b0);
    cyc();
    idle();

    // Bus hold for 3 cycles with jump 0x200 in the first; later ex jump ignored.
    hold_req_rib_xi = 1'b1; jmp_req_ex_xi = 1'b1; jmp_addr_ex_xi = 32'h200;
    #1;
    chk_out("rib_c1", 1'b0, 32'h0, 3'd1, 1'b0, 1'b0);
    cyc();
    jmp_addr_ex_xi = 32'h999;
    #1;
    chk_out("rib_c2", 1'b0, 32'h0, 3'd1, 1'b1, 1'b0);
    cyc();
    jmp_req_ex_xi = 1'b0;
    #1;
    chk_out("rib_c3", 1'b0, 32'h0, 3'd1, 1'b1, 1'b0);
    cyc();
    hold_req_rib_xi = 1'b0;
    #1;
    chk_out("rib_issue", 1'b1, 32'h200, 3'd3, 1'b1, 1'b0);
    cyc();
    #1;
    chk_out("rib_done", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    cyc();

    // Interrupt beats execute jump in the same cycle.
    int_req_xi = 1'b1; int_addr_xi = 32'h80;
    jmp_req_ex_xi = 1'b1; jmp_addr_ex_xi = 32'h200;
    #1;
    chk_out("prio", 1'b1, 32'h80, 3'd3, 1'b0, 1'b0);
    cyc();
    idle();
    #1;
    chk_out("prio_drop", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    cyc();

    // Priority under bus hold, then interrupt overwrites the pending target.
    hold_req_rib_xi = 1'b1;
    int_req_xi = 1'b1; int_addr_xi = 32'h80;
    jmp_req_ex_xi = 1'b1; jmp_addr_ex_xi = 32'h200;
    cyc();
    jmp_req_ex_xi = 1'b0;
    int_addr_xi = 32'h440;
    #1;
    chk_out("ovw_pend", 1'b0, 32'h0, 3'd1, 1'b1, 1'b0);
    cyc();
    idle();
    #1;
    chk_out("ovw_issue", 1'b1, 32'h440, 3'd3, 1'b1, 1'b0);
    cyc();

    // Halt while pending on 0x300 for 5 cycles, then single redirect.
    hold_req_rib_xi = 1'b1; jmp_req_ex_xi = 1'b1; jmp_addr_ex_xi = 32'h300;
    cyc();
    idle();
    halt_req_jtag_xi = 1'b1;
    #1;
    chk_out("halt_c1", 1'b0, 32'h0, 3'd3, 1'b1, 1'b0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_out("halt_cn", 1'b0, 32'h0, 3'd3, 1'b1, 1'b1);
      cyc();
    end
    halt_req_jtag_xi = 1'b0;
    #1;
    chk_out("halt_rel", 1'b0, 32'h0, 3'd3, 1'b1, 1'b1);
    cyc();
    #1;
    chk_out("halt_issue", 1'b1, 32'h300, 3'd3, 1'b1, 1'b0);
    cyc();
    #1;
    chk_out("halt_done", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    cyc();

    // Reset while pending discards the captured redirect.
    hold_req_rib_xi = 1'b1; jmp_req_ex_xi = 1'b1; jmp_addr_ex_xi = 32'h500;
    cyc();
    idle();
    hold_req_rib_xi = 1'b1;
    #1;
    check("rstpend.pend_before", 32'(pend_xo), 32'h1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle();
    #1;
    chk_out("rstpend_after", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    cyc();

    // Bus hold for 4 consecutive cycles reaches the timeout threshold.
    hold_req_rib_xi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("to_during", 32'(hold_timeout_xo), 32'h0);
      cyc();
    end
    idle();
    #1;
    check("to_set", 32'(hold_timeout_xo), 32'(TO_EN));
    chk_out("to_idle", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    cyc();
    cyc();
    #1;
    check("to_sticky", 32'(hold_timeout_xo), 32'(TO_EN));
    rst = 1'b1;
    #1;
    check("to_rst", 32'(hold_timeout_xo), 32'h0);
    cyc();
    rst = 1'b0;
    #1;
    check("to_cleared", 32'(hold_timeout_xo), 32'h0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
